// File: rtl/edu_tpu_sa.sv
// Wishbone-mapped NxN output-stationary systolic matrix multiplier (C = A*B).
// Host loads A/B, writes START, polls STATUS or waits for irq, then reads C.
module edu_tpu_sa #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          N         = 4,
  parameter int          DW        = 8,
  parameter int          ACC_W     = 2*DW + $clog2(N)
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_i,
  input  logic        caravel_wb_stb_i,
  input  logic        caravel_wb_cyc_i,
  input  logic        caravel_wb_we_i,
  input  logic [3:0]  caravel_wb_sel_i,
  input  logic [31:0] caravel_wb_dat_i,
  input  logic [31:0] caravel_wb_adr_i,
  output logic        caravel_wb_ack_o,
  output logic [31:0] caravel_wb_dat_o,
  output logic        irq_o,
  output logic        busy_o
);

  localparam int LAST_T = 3*N - 2;
  localparam int TW     = $clog2(3*N);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN} state_t;

  state_t          r_state, w_state_next;
  logic [TW-1:0]   r_t, w_t_next;

  logic            r_ack;
  logic [31:0]     r_dat;
  logic            r_irq_en;
  logic            r_done;
  logic            r_err;

  logic signed [DW-1:0]    r_a [N][N];
  logic signed [DW-1:0]    r_b [N][N];
  logic signed [DW-1:0]    w_feed_a [N];
  logic signed [DW-1:0]    w_feed_b [N];
  logic signed [DW-1:0]    w_pa  [N][N];
  logic signed [DW-1:0]    w_pb  [N][N];
  logic signed [ACC_W-1:0] w_acc [N][N];

  // ---------------- bus decode ----------------
  logic        w_hit, w_req, w_ack_next, w_wr, w_busy;
  logic [1:0]  w_region;
  logic [5:0]  w_widx;
  logic        w_idx_ok;
  logic        w_is_ctrl, w_is_status, w_is_a, w_is_b, w_is_c;
  logic        w_start, w_load_ab, w_err_set, w_run_end;
  logic [31:0] w_rd_data;
  logic        w_unused;

  assign w_hit       = (caravel_wb_adr_i[31:10] == BASE_ADDR[31:10]);
  assign w_req       = caravel_wb_stb_i & caravel_wb_cyc_i & w_hit;
  assign w_ack_next  = w_req & ~r_ack;
  // A write lands at the end of its ack cycle, while the master still holds the bus.
  assign w_wr        = r_ack & w_req & caravel_wb_we_i & (caravel_wb_sel_i != 4'b0000);
  assign w_region    = caravel_wb_adr_i[9:8];
  assign w_widx      = caravel_wb_adr_i[7:2];
  assign w_idx_ok    = ({1'b0, w_widx} < 7'(N*N));
  assign w_is_ctrl   = (w_region == 2'd0) && (w_widx == 6'd0);
  assign w_is_status = (w_region == 2'd0) && (w_widx == 6'd1);
  assign w_is_a      = (w_region == 2'd1) && w_idx_ok;
  assign w_is_b      = (w_region == 2'd2) && w_idx_ok;
  assign w_is_c      = (w_region == 2'd3) && w_idx_ok;
  assign w_busy      = (r_state != S_IDLE);
  assign w_start     = w_wr & w_is_ctrl & caravel_wb_dat_i[0] & ~w_busy;
  assign w_load_ab   = w_wr & (w_is_a | w_is_b) & ~w_busy;
  assign w_err_set   = w_wr & w_busy & (w_is_a | w_is_b | (w_is_ctrl & caravel_wb_dat_i[0]));
  assign w_run_end   = (r_state == S_RUN) && (r_t == TW'(LAST_T));
  assign w_unused    = ^{caravel_wb_adr_i[1:0], caravel_wb_dat_i};

  always_comb begin
    w_rd_data = '0;
    if (w_is_ctrl)   w_rd_data = {30'b0, r_irq_en, 1'b0};
    if (w_is_status) w_rd_data = {29'b0, r_err, r_done, w_busy};
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (w_widx == 6'(i*N + j)) begin
          if (w_is_a) w_rd_data = 32'(r_a[i][j]);
          if (w_is_b) w_rd_data = 32'(r_b[i][j]);
          if (w_is_c) w_rd_data = 32'(w_acc[i][j]);
        end
      end
    end
  end

  // ---------------- control / status registers ----------------
  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ack <= w_ack_next;
      r_dat <= (w_ack_next & ~caravel_wb_we_i) ? w_rd_data : '0;
      if (w_wr & w_is_ctrl)
        r_irq_en <= caravel_wb_dat_i[1];
      // Completion beats a simultaneous host clear so no finished run goes unseen.
      if (w_run_end)
        r_done <= 1'b1;
      else if (w_start)
        r_done <= 1'b0;
      else if (w_wr & w_is_status & caravel_wb_dat_i[1])
        r_done <= 1'b0;
      if (w_err_set)
        r_err <= 1'b1;
      else if (w_wr & w_is_status & caravel_wb_dat_i[2])
        r_err <= 1'b0;
    end
  end

  // ---------------- operand storage ----------------
  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
        end
      end
    end else if (w_load_ab) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (w_widx == 6'(i*N + j)) begin
            if (w_is_a) r_a[i][j] <= caravel_wb_dat_i[DW-1:0];
            if (w_is_b) r_b[i][j] <= caravel_wb_dat_i[DW-1:0];
          end
        end
      end
    end
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge caravel_wb_clk_i) begin
    if (caravel_wb_rst_i) begin
      r_state <= S_IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_next;
      r_t     <= w_t_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_t_next     = r_t;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_next = S_RUN;
        w_t_next     = '0;
      end
      S_RUN: begin
        if (r_t == TW'(LAST_T)) begin
          w_state_next = S_IDLE;
          w_t_next     = '0;
        end else begin
          w_t_next = r_t + TW'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_t_next     = '0;
      end
    endcase
  end

  // Skewed edge feed: row i carries A[i][t-i], column j carries B[t-j][j]; zero outside.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_feed_a[i] = '0;
      w_feed_b[i] = '0;
    end
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(r_t) == i + k) begin
          w_feed_a[i] = r_a[i][k];
          w_feed_b[i] = r_b[k][i];
        end
      end
    end
  end

  // ---------------- processing element grid ----------------
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [DW-1:0]    w_ain, w_bin, r_pa, r_pb;
      logic signed [2*DW-1:0]  w_prod;
      logic signed [ACC_W-1:0] r_acc;

      if (gj == 0) begin : g_ledge
        assign w_ain = w_feed_a[gi];
      end else begin : g_linner
        assign w_ain = w_pa[gi][gj-1];
      end
      if (gi == 0) begin : g_tedge
        assign w_bin = w_feed_b[gj];
      end else begin : g_tinner
        assign w_bin = w_pb[gi-1][gj];
      end

      assign w_prod = w_ain * w_bin;

      always_ff @(posedge caravel_wb_clk_i) begin
        if (caravel_wb_rst_i || (r_state == S_CLEAR)) begin
          r_pa  <= '0;
          r_pb  <= '0;
          r_acc <= '0;
        end else if (r_state == S_RUN) begin
          r_pa  <= w_ain;
          r_pb  <= w_bin;
          r_acc <= r_acc + ACC_W'(w_prod);
        end
      end

      assign w_pa[gi][gj]  = r_pa;
      assign w_pb[gi][gj]  = r_pb;
      assign w_acc[gi][gj] = r_acc;
    end
  end

  assign caravel_wb_ack_o = r_ack;
  assign caravel_wb_dat_o = r_dat;
  assign irq_o            = r_done & r_irq_en;
  assign busy_o           = w_busy;

endmodule
